// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute hazard-control bundle: decode instruction fields, pipe
// events and writeback in; issue/stall/flush, mul/div handshake and scoreboard out.
interface pipe_hazard_ctrl_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
);
  localparam int RW = $clog2(NREG);

  logic            d_valid;
  logic [RW-1:0]   d_rs1;
  logic [RW-1:0]   d_rs2;
  logic            d_use_rs1;
  logic            d_use_rs2;
  logic [RW-1:0]   d_rd;
  logic            d_wen;
  logic            d_is_load;
  logic            d_is_muldiv;
  logic            mem_busy;
  logic            branch;
  logic            wb_valid;
  logic [RW-1:0]   wb_dst;
  logic            wb_long;

  logic            issue;
  logic            stall_d;
  logic            flush_d;
  logic            md_start;
  logic            md_busy;
  logic [NREG-1:0] pending;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wen,
           d_is_load, d_is_muldiv, mem_busy, branch, wb_valid, wb_dst, wb_long,
    input  issue, stall_d, flush_d, md_start, md_busy, pending, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wen,
           d_is_load, d_is_muldiv, mem_busy, branch, wb_valid, wb_dst, wb_long,
    output issue, stall_d, flush_d, md_start, md_busy, pending, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Decode-to-execute issue controller: long-latency scoreboard, shared mul/div
// sequencer, stall/flush/issue generation and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int NREG       = 32,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int MW = $clog2(MULDIV_LAT);
  localparam logic [MW-1:0] MD_LAST = MW'(MULDIV_LAT - 1);

  typedef enum logic {S_IDLE, S_BUSY} md_state_e;

  md_state_e        r_md_state;
  md_state_e        w_md_state_nxt;
  logic [MW-1:0]    r_md_cnt;
  logic [NREG-1:0]  r_pending;
  logic [NREG-1:0]  w_set_vec;
  logic [NREG-1:0]  w_clr_vec;
  logic [CNT_W-1:0] r_stall_cnt;
  logic w_raw, w_waw, w_struct, w_hazard, w_md_busy;
  logic w_issue, w_stall, w_flush, w_md_start, w_cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_md_busy = (r_md_state == S_BUSY);
  assign w_raw     = (bus.d_use_rs1 & r_pending[bus.d_rs1]) |
                     (bus.d_use_rs2 & r_pending[bus.d_rs2]);
  assign w_waw     = bus.d_wen & r_pending[bus.d_rd];
  assign w_struct  = bus.d_is_muldiv & w_md_busy;
  assign w_hazard  = w_raw | w_waw | w_struct;

  // Combinational outputs stay low while reset is held, whatever decode presents
  always_comb begin
    w_issue = 1'b0;
    w_stall = 1'b0;
    w_flush = 1'b0;
    if (reset) begin
      if (bus.branch) begin
        w_flush = 1'b1;
      end else if (bus.mem_busy) begin
        w_stall = 1'b1;
      end else if (bus.d_valid && w_hazard) begin
        w_stall = 1'b1;
      end else begin
        w_issue = bus.d_valid;
      end
    end
  end

  always_comb begin
    w_md_state_nxt = r_md_state;
    w_md_start     = 1'b0;
    case (r_md_state)
      S_IDLE: begin
        if (w_issue && bus.d_is_muldiv) begin
          w_md_start     = 1'b1;
          w_md_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_md_cnt == MD_LAST) w_md_state_nxt = S_IDLE;
      end
      default: w_md_state_nxt = S_IDLE;
    endcase
  end

  // Set is OR-ed in after the clear so a newer producer keeps its register
  assign w_set_vec = (w_issue && bus.d_wen && (bus.d_is_load || bus.d_is_muldiv) &&
                      (bus.d_rd != '0)) ? (NREG'(1) << bus.d_rd) : '0;
  assign w_clr_vec = (bus.wb_valid && bus.wb_long && (bus.wb_dst != '0)) ?
                     (NREG'(1) << bus.wb_dst) : '0;
  assign w_cnt_en  = bus.d_valid & w_stall & ~bus.branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_state  <= S_IDLE;
      r_md_cnt    <= '0;
      r_pending   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_md_state  <= w_md_state_nxt;
      r_md_cnt    <= (w_md_busy && (r_md_cnt != MD_LAST)) ? r_md_cnt + MW'(1) : '0;
      r_pending   <= (r_pending & ~w_clr_vec) | w_set_vec;
      if (w_cnt_en) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.issue     = w_issue;
  assign bus.stall_d   = w_stall;
  assign bus.flush_d   = w_flush;
  assign bus.md_start  = w_md_start;
  assign bus.md_busy   = w_md_busy;
  assign bus.pending   = r_pending;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Scoreboard-based issue controller between decode and execute of the 5-stage pipeline.
- Tracks destination registers of long-latency producers (loads, mul/div) whose results the M/W forwarding paths cannot yet supply.
- Sequences the shared multi-cycle mul/div unit.
- Produces the decode-stage stall, flush and issue signals, plus a stall performance counter.

Parameters:
- NREG, 32, architectural register count; index 0 is hardwired zero.
- MULDIV_LAT, 4, number of cycles the mul/div unit stays busy per operation; must be ≥2.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  decode holds a valid instruction.
- d_rs1  in  5  source register 1.
- d_rs2  in  5  source register 2.
- d_use_rs1  in  1  instruction reads rs1.
- d_use_rs2  in  1  instruction reads rs2.
- d_rd  in  5  destination register.
- d_wen  in  1  instruction writes rd.
- d_is_load  in  1  instruction is a load.
- d_is_muldiv  in  1  instruction uses the mul/div unit.
- mem_busy  in  1  data memory not ready; whole pipe must hold.
- branch  in  1  taken branch/jump resolved this cycle.
- wb_valid  in  1  writeback commits this cycle.
- wb_dst  in  5  writeback destination.
- wb_long  in  1  writeback carries a load or mul/div result.
- issue  out  1  decode instruction advances to execute this cycle.
- stall_d  out  1  hold the decode pipeline register (drives decode stall).
- flush_d  out  1  invalidate the decode pipeline register.
- md_start  out  1  one-cycle pulse that starts the mul/div unit.
- md_busy  out  1  mul/div unit is occupied.
- pending  out  NREG  scoreboard vector; bit 0 is always 0.
- stall_cnt  out  CNT_W  count of stalled valid-decode cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - pending=0, mul/div FSM to IDLE, internal counter=0, stall_cnt=0.
  - All combinational outputs are forced to 0 while reset is low.
- Hazard terms (combinational):
  - raw = (d_use_rs1 & pending[d_rs1]) | (d_use_rs2 & pending[d_rs2]).
  - waw = d_wen & pending[d_rd].
  - struct = d_is_muldiv & md_busy.
- Output priority (highest first):
  1. branch: flush_d=1, stall_d=0, issue=0.
  2. mem_busy: stall_d=1, issue=0.
  3. d_valid & (raw|waw|struct): stall_d=1, issue=0.
  4. Otherwise: issue=d_valid, stall_d=0.
- flush_d equals branch; it is not registered.
- Issue has zero latency (same cycle). Scoreboard and FSM effects become visible after the next rising edge.
- Scoreboard:
  - Set pending[d_rd] when issue & d_wen & (d_is_load|d_is_muldiv) & d_rd≠0.
  - Clear pending[wb_dst] when wb_valid & wb_long & wb_dst≠0.
  - If set and clear hit the same register in the same cycle, set wins (the newer producer owns it).
  - Writebacks of short ALU ops never touch pending.
- Mul/div FSM:
  - IDLE: on issue & d_is_muldiv, pulse md_start=1 (same cycle as issue), go to BUSY, cnt=0.
  - BUSY: md_busy=1, cnt increments every cycle, independent of mem_busy and branch. When cnt==MULDIV_LAT-1, return to IDLE.
  - md_busy is therefore high for exactly MULDIV_LAT cycles. A second mul/div can issue in the first IDLE cycle.
  - branch does not abort BUSY: the operation in flight is older than the branch.
- stall_cnt:
  - Increments on any cycle with d_valid & stall_d & ~branch.
  - Saturates at all-ones and never wraps.
- Reset asserted mid-operation: all state clears immediately, and pending producers are forgotten. Upstream must flush the pipe on the same reset.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0. Release, then d_valid=1 with ALU op rd=5 → issue=1, pending stays 0.
- Load-use: issue load rd=3; next cycle d_use_rs1=1, rs1=3 → stall_d=1, issue=0, stall_cnt increments each cycle. Then wb_valid=1, wb_long=1, wb_dst=3 → issue=1 the cycle after, pending[3]=0.
- Mul/div structural, MULDIV_LAT=4: issue muldiv rd=7 → md_start pulses once and md_busy is high 4 cycles. A second muldiv (rd=8) stalls exactly those 4 cycles, then issues with md_start=1.
- Set/clear collision: pending[9]=1; wb clears 9 in the same cycle a new load rd=9 issues → pending[9]=1 afterwards. WAW on rd=9 then stalls an ALU op writing x9.
- Priority: branch=1 together with mem_busy=1 and a RAW hazard → flush_d=1, stall_d=0, issue=0, stall_cnt unchanged. Next cycle mem_busy=1 alone → stall_d=1.
- x0 and saturation: load rd=0 → pending stays 0. Preload stall_cnt near all-ones (CNT_W=4, 14 stalls) and stall 3 more cycles → stall_cnt=15.
